// File: rtl/alu_wide_op_ctrl.sv
// Sequencer that runs WIDTH-bit operations through one external 8-bit 74181 pair,
// one byte slice per cycle, LSB first. Optional flags: define ALU_FLAGS_EN.
module alu_wide_op_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             op_cn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef ALU_FLAGS_EN
    output logic             zero,
    output logic             equal,
`endif
    output logic             cn_out,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cn,
    input  logic [7:0]       alu_f,
    input  logic             alu_cn4,
    input  logic             alu_eq
);

    localparam int NSLICE = WIDTH / 8;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [NSLICE-1:0][7:0] a_reg, b_reg, res_reg, res_nxt;
    logic [3:0]             s_reg;
    logic                   m_reg;
    logic                   carry_reg;
    logic                   cn_out_reg;
    logic [IDX_W-1:0]       idx;
    logic                   accept;
    logic                   last_slice;

    assign last_slice = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result with the current slice merged in; the flags look at this on the last edge.
    always_comb begin
        res_nxt      = res_reg;
        res_nxt[idx] = alu_f;
    end

    // NOTE: sequential state is assigned with <= so every register samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            s_reg      <= '0;
            m_reg      <= 1'b0;
            carry_reg  <= 1'b0;
            idx        <= '0;
            res_reg    <= '0;
            cn_out_reg <= 1'b1;
        end else if (accept) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            s_reg     <= op_s;
            m_reg     <= op_m;
            carry_reg <= op_cn;
            idx       <= '0;
            res_reg   <= '0;
        end else if (state == RUN) begin
            res_reg   <= res_nxt;
            carry_reg <= alu_cn4;
            if (last_slice) begin
                cn_out_reg <= alu_cn4;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign result = res_reg;
    assign cn_out = cn_out_reg;

    // The ALU sees the latched operation only while a slice is in flight.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_s  = '0;
        alu_m  = 1'b0;
        alu_cn = 1'b0;
        if (state == RUN) begin
            alu_a  = a_reg[idx];
            alu_b  = b_reg[idx];
            alu_s  = s_reg;
            alu_m  = m_reg;
            alu_cn = carry_reg;
        end
    end

`ifdef ALU_FLAGS_EN
    logic eq_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_acc <= 1'b0;
            zero   <= 1'b0;
            equal  <= 1'b0;
        end else if (accept) begin
            eq_acc <= 1'b1;
            zero   <= 1'b0;
            equal  <= 1'b0;
        end else if (state == RUN) begin
            eq_acc <= eq_acc & alu_eq;
            if (last_slice) begin
                zero  <= (res_nxt == '0);
                equal <= eq_acc & alu_eq;
            end
        end
    end
`else
    logic unused_eq;
    assign unused_eq = alu_eq;
`endif

endmodule

// File: tb/tb_alu_wide_op_ctrl.sv
// Scoreboard bench for alu_wide_op_ctrl: a 74181 byte model drives the ALU ports and a
// wide reference model built from the 74181 function table predicts every result.
module tb_alu_wide_op_ctrl;

    localparam int W      = 32;
    localparam int NSLICE = W / 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic [3:0]   op_s;
    logic         op_m, op_cn;
    logic         busy, done, cn_out;
    logic [W-1:0] result;
    logic [7:0]   alu_a, alu_b, alu_f;
    logic [3:0]   alu_s;
    logic         alu_m, alu_cn, alu_cn4, alu_eq;
`ifdef ALU_FLAGS_EN
    logic         zero, equal;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   s;
        logic         m;
        logic         cn;
        logic [W-1:0] res;
        logic         cn_out;
        logic         zero;
        logic         equal;
        int           start_cyc;
    } exp_t;

    exp_t sb_q[$];

    alu_wide_op_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cn(op_cn),
        .busy(busy), .done(done), .result(result),
`ifdef ALU_FLAGS_EN
        .zero(zero), .equal(equal),
`endif
        .cn_out(cn_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
        .alu_f(alu_f), .alu_cn4(alu_cn4), .alu_eq(alu_eq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide 74181 (active-high data): propagate/generate terms, active-low carries.
    function automatic logic [8:0] alu181(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s, input logic m, input logic cn);
        logic [7:0] x, y;
        logic [8:0] sum;
        x   = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
        y   = (a & b & {8{s[3]}}) | (a & ~b & {8{s[2]}});
        sum = {1'b0, x} + {1'b0, y} + {8'd0, ~cn};
        return {~sum[8], (m ? ~(x ^ y) : sum[7:0])};
    endfunction

    always_comb begin
        {alu_cn4, alu_f} = alu181(alu_a, alu_b, alu_s, alu_m, alu_cn);
        alu_eq           = (alu_a == alu_b);
    end

    // Wide reference straight from the function table: arithmetic ops as two addends
    // (with Cn=1 meaning no carry in), logic ops as named boolean functions.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] s, input logic m, input logic cn);
        exp_t         e;
        logic [W-1:0] ones, p, q, lf;
        logic [W:0]   sum;
        ones = '1;
        case (s)
            4'd0:  begin p = a;          q = '0;     end
            4'd1:  begin p = a | b;      q = '0;     end
            4'd2:  begin p = a | ~b;     q = '0;     end
            4'd3:  begin p = ones;       q = '0;     end
            4'd4:  begin p = a;          q = a & ~b; end
            4'd5:  begin p = a | b;      q = a & ~b; end
            4'd6:  begin p = a;          q = ~b;     end
            4'd7:  begin p = a & ~b;     q = ones;   end
            4'd8:  begin p = a;          q = a & b;  end
            4'd9:  begin p = a;          q = b;      end
            4'd10: begin p = a | ~b;     q = a & b;  end
            4'd11: begin p = a & b;      q = ones;   end
            4'd12: begin p = a;          q = a;      end
            4'd13: begin p = a | b;      q = a;      end
            4'd14: begin p = a | ~b;     q = a;      end
            default: begin p = a;        q = ones;   end
        endcase
        case (s)
            4'd0:  lf = ~a;
            4'd1:  lf = ~(a | b);
            4'd2:  lf = ~a & b;
            4'd3:  lf = '0;
            4'd4:  lf = ~(a & b);
            4'd5:  lf = ~b;
            4'd6:  lf = a ^ b;
            4'd7:  lf = a & ~b;
            4'd8:  lf = ~a | b;
            4'd9:  lf = ~(a ^ b);
            4'd10: lf = b;
            4'd11: lf = a & b;
            4'd12: lf = ones;
            4'd13: lf = a | ~b;
            4'd14: lf = a | b;
            default: lf = a;
        endcase
        sum       = {1'b0, p} + {1'b0, q} + {{W{1'b0}}, ~cn};
        e.a       = a;
        e.b       = b;
        e.s       = s;
        e.m       = m;
        e.cn      = cn;
        e.res     = m ? lf : sum[W-1:0];
        e.cn_out  = ~sum[W];
        e.zero    = (e.res == '0);
        e.equal   = (a == b);
        e.start_cyc = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scramble_inputs();
        op_a  = $urandom;
        op_b  = $urandom;
        op_s  = 4'($urandom);
        op_m  = 1'($urandom);
        op_cn = 1'($urandom);
    endtask

    // Called #1 after a rising edge; returns one cycle later with start low again.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                         input logic m, input logic cn, input bit expect_done);
        exp_t e;
        op_a  = a;
        op_b  = b;
        op_s  = s;
        op_m  = m;
        op_cn = cn;
        start = 1'b1;
        if (expect_done) begin
            e           = model(a, b, s, m, cn);
            e.start_cyc = cyc;
            sb_q.push_back(e);
        end
        wait_cycles(1);
        start = 1'b0;
        scramble_inputs();
    endtask

    // Leaves the bench in the cycle right after done, where the next start is legal.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic cn);
        issue(a, b, s, m, cn, 1'b1);
        wait_cycles(NSLICE + 1);
    endtask

    // Monitor: compares slices, completion and hold behaviour against the scoreboard.
    initial begin
        exp_t h, last;
        bit   have_last;
        int   off;
        have_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_last = 1'b0;
            end else begin
                if (!busy) begin
                    check("alu_idle", {alu_a, alu_b, alu_s, alu_m, alu_cn}, '0);
                    if (have_last) check("result_held", result, last.res);
                end
                if (sb_q.size() > 0) begin
                    h   = sb_q[0];
                    off = cyc - h.start_cyc;
                    if (off >= 1 && off <= NSLICE) begin
                        check("alu_a_slice", alu_a, h.a[8*(off-1) +: 8]);
                        check("alu_b_slice", alu_b, h.b[8*(off-1) +: 8]);
                        check("alu_sm", {alu_s, alu_m}, {h.s, h.m});
                        if (off == 1) check("alu_cn_first", alu_cn, h.cn);
                    end
                    if (done) begin
                        check("latency", 64'(off), 64'(NSLICE + 1));
                        check("result", result, h.res);
                        check("cn_out", cn_out, h.cn_out);
`ifdef ALU_FLAGS_EN
                        check("zero", zero, h.zero);
                        check("equal", equal, h.equal);
`endif
                        last      = h;
                        have_last = 1'b1;
                        void'(sb_q.pop_front());
                    end
                end else if (done) begin
                    check("unexpected_done", done, 1'b0);
                end
            end
        end
    end

    initial begin
        int budget;
        rst   = 1'b1;
        start = 1'b0;
        scramble_inputs();
        wait_cycles(2);
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_result", result, '0);
        check("rst_cn_out", cn_out, 1'b1);
        check("rst_alu", {alu_a, alu_b, alu_s, alu_m, alu_cn}, '0);
`ifdef ALU_FLAGS_EN
        check("rst_flags", {zero, equal}, 2'b00);
`endif
        rst = 1'b0;
        wait_cycles(2);

        // Directed cases: add, overflow through all slices, subtract, logic xor.
        run_op(32'h0000_00FF, 32'h0000_0001, 4'b1001, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b1);
        run_op(32'h0000_0005, 32'h0000_0003, 4'b0110, 1'b0, 1'b0);
        run_op(32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'b0110, 1'b1, 1'b0);

        // start while running and while in DONE must both be ignored.
        issue(32'h1234_5678, 32'h1111_1111, 4'b1001, 1'b0, 1'b1, 1'b1);
        wait_cycles(1);
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'h0F0F_0F0F;
        op_s  = 4'b0110;
        start = 1'b1;
        wait_cycles(1);
        start = 1'b0;
        wait_cycles(NSLICE - 2);
        op_a  = 32'hCAFE_F00D;
        start = 1'b1;
        wait_cycles(1);
        start = 1'b0;
        wait_cycles(1);

        // Abort after two slices: outputs back to reset values, no done afterwards.
        issue(32'h0101_0101, 32'h0101_0101, 4'b1001, 1'b0, 1'b1, 1'b0);
        wait_cycles(2);
        rst = 1'b1;
        #1;
        check("abort_busy_done", {busy, done}, 2'b00);
        check("abort_result", result, '0);
        check("abort_cn_out", cn_out, 1'b1);
        check("abort_alu", {alu_a, alu_b, alu_s, alu_m, alu_cn}, '0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(NSLICE + 3);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b1);

        // Random operations, some with equal operands, back-to-back or with small gaps.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            run_op(a, b, 4'($urandom), 1'($urandom), 1'($urandom));
            wait_cycles($urandom_range(0, 2));
        end

        budget = 0;
        while (sb_q.size() > 0 && budget < 50) begin
            wait_cycles(1);
            budget++;
        end
        wait_cycles(3);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
